// File: rtl/protocol_framer.sv
`default_nettype none
// ============================================================================
// Module   : protocol_framer
// Function : Snapshots channel values and switch flags on start, then streams
//            SOF, encoded channel bytes and an optional checksum over valid/ready.
// Revision : 1.0
// ============================================================================
module protocol_framer #(
  parameter int         CHANNELS    = 4,
  parameter int         SW_THRESH   = 20,
  parameter logic [7:0] START_BYTE  = 8'hFF,
  parameter logic [7:0] SW_ON_CODE  = 8'h01,
  parameter logic [7:0] SW_OFF_CODE = 8'h02,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CHANNELS*8-1:0] ch_data,
  input  logic [CHANNELS-1:0]   ch_sig,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int              IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(CHANNELS - 1);
  localparam logic [7:0]       c_thresh   = 8'(SW_THRESH);
  localparam logic [7:0]       c_escape   = START_BYTE - 8'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SOF  = 2'd1,
    S_CHAN = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  state_t                r_state;
  logic [CHANNELS*8-1:0] r_snap_data;
  logic [CHANNELS-1:0]   r_snap_sig;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_sum;

  logic [IDX_W-1:0]      w_next_idx;
  logic [7:0]            w_cur_enc;
  logic [7:0]            w_next_enc;
  logic [7:0]            w_sum_next;
  logic                  w_accept;

  // Switcher codes win below the threshold; the escape clamp keeps the marker out of the payload.
  function automatic logic [7:0] encode(input logic [7:0] v, input logic s);
    if (v < c_thresh)
      return s ? SW_ON_CODE : SW_OFF_CODE;
    else if (v == START_BYTE)
      return c_escape;
    else
      return v;
  endfunction

  assign w_next_idx = (r_state == S_SOF) ? '0 : IDX_W'(r_idx + 1'b1);
  assign w_accept   = tx_valid && tx_ready;
  assign w_sum_next = r_sum + w_cur_enc;

  always_comb begin
    w_cur_enc  = '0;
    w_next_enc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_idx == IDX_W'(i))
        w_cur_enc = encode(r_snap_data[8*i +: 8], r_snap_sig[i]);
      if (w_next_idx == IDX_W'(i))
        w_next_enc = encode(r_snap_data[8*i +: 8], r_snap_sig[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_snap_data <= '0;
      r_snap_sig  <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap_data <= ch_data;
            r_snap_sig  <= ch_sig;
            r_idx       <= '0;
            r_sum       <= '0;
            tx_data     <= START_BYTE;
            tx_valid    <= 1'b1;
            busy        <= 1'b1;
            r_state     <= S_SOF;
          end
        end
        S_SOF: begin
          if (w_accept) begin
            tx_data <= w_next_enc;
            r_idx   <= w_next_idx;
            r_state <= S_CHAN;
          end
        end
        S_CHAN: begin
          if (w_accept) begin
            r_sum <= w_sum_next;
            if (r_idx == c_last_idx) begin
              if (CHECKSUM_EN) begin
                tx_data <= {1'b0, w_sum_next[6:0]};
                r_state <= S_CSUM;
              end else begin
                tx_valid   <= 1'b0;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                r_state    <= S_IDLE;
              end
            end else begin
              tx_data <= w_next_enc;
              r_idx   <= w_next_idx;
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_protocol_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_protocol_framer
// Function : Scoreboard bench for protocol_framer (4-channel with checksum and
//            1-channel without).
// Revision : 1.0
// ============================================================================
module tb_protocol_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_b;
  logic [31:0] ch_data;
  logic [3:0]  ch_sig;
  logic [7:0]  ch_data_b;
  logic [0:0]  ch_sig_b;
  logic [7:0]  tx_data, tx_data_b;
  logic        tx_valid, tx_valid_b;
  logic        tx_ready, tx_ready_b;
  logic        busy, busy_b;
  logic        frame_done, frame_done_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] held_a = '0, held_b = '0;

  always #5 clk = ~clk;

  protocol_framer u_dut (
    .clk(clk), .reset(reset), .start(start), .ch_data(ch_data), .ch_sig(ch_sig),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  protocol_framer #(.CHANNELS(1), .CHECKSUM_EN(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ch_data(ch_data_b), .ch_sig(ch_sig_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push6(input logic [47:0] bytes);
    for (int i = 5; i >= 0; i--) qa.push_back(bytes[8*i +: 8]);
  endtask

  task automatic wait_idle_a(input int budget);
    int n;
    n = 0;
    while ((busy || qa.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check_val("idle_in_budget", 32'(n < budget), 1);
    tick();
  endtask

  // Byte scoreboard plus hold-stability checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      hold_a <= 1'b0;
    end else begin
      if (hold_a) begin
        check_val("hold_valid", 32'(tx_valid), 1);
        check_val("hold_data", 32'(tx_data), 32'(held_a));
      end
      if (tx_valid && tx_ready) begin
        if (qa.size() == 0) check_val("extra_byte_qdepth", qa.size(), 1);
        else check_val("byte", 32'(tx_data), 32'(qa.pop_front()));
      end
      hold_a <= tx_valid && !tx_ready;
      held_a <= tx_data;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_b <= 1'b0;
    end else begin
      if (hold_b) check_val("hold_data_b", 32'(tx_data_b), 32'(held_b));
      if (tx_valid_b && tx_ready_b) begin
        if (qb.size() == 0) check_val("extra_byte_b_qdepth", qb.size(), 1);
        else check_val("byte_b", 32'(tx_data_b), 32'(qb.pop_front()));
      end
      hold_b <= tx_valid_b && !tx_ready_b;
      held_b <= tx_data_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; start_b = 1'b0;
    ch_data = '0; ch_sig = '0; ch_data_b = '0; ch_sig_b = '0;
    tx_ready = 1'b1; tx_ready_b = 1'b1;
    tick(); tick();
    check_val("rst_valid", 32'(tx_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(frame_done), 0);
    check_val("rst_data", 32'(tx_data), 0);
    check_val("rst_valid_b", 32'(tx_valid_b), 0);
    reset = 1'b0;
    tick();

    // Basic frame with exact cycle timing
    ch_data = {8'd50, 8'd5, 8'hFF, 8'd19};
    ch_sig  = 4'b0001;
    push6(48'hFF_01_FE_02_32_33);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_val("t1_busy", 32'(busy), 1);
      check_val("t1_valid", 32'(tx_valid), 1);
      tick();
    end
    check_val("t1_done", 32'(frame_done), 1);
    check_val("t1_busy_end", 32'(busy), 0);
    check_val("t1_valid_end", 32'(tx_valid), 0);
    tick();
    check_val("t1_done_pulse", 32'(frame_done), 0);
    check_val("t1_q_empty", qa.size(), 0);

    // Backpressure: ready pattern 1,0,0,1,...
    push6(48'hFF_01_FE_02_32_33);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      tx_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    check_val("t2_in_budget", 32'(n < 200), 1);
    tx_ready = 1'b1;
    tick();
    check_val("t2_q_empty", qa.size(), 0);

    // Threshold boundary and snapshot isolation
    ch_data = {8'hFE, 8'h00, 8'h00, 8'd20};
    ch_sig  = 4'b0010;
    push6(48'hFF_14_01_02_FE_15);
    start = 1'b1; tick(); start = 1'b0;
    ch_data = '0; ch_sig = '0;
    wait_idle_a(100);

    // Start while busy is ignored; start in frame_done cycle is taken
    ch_data = {8'd50, 8'd5, 8'hFF, 8'd19};
    ch_sig  = 4'b0001;
    push6(48'hFF_01_FE_02_32_33);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!frame_done && n < 50) begin
      tick();
      n++;
    end
    check_val("t4_done_seen", 32'(frame_done), 1);
    check_val("t4_q_empty", qa.size(), 0);
    push6(48'hFF_01_FE_02_32_33);
    start = 1'b1; tick(); start = 1'b0;
    check_val("t4_sof_valid", 32'(tx_valid), 1);
    check_val("t4_sof_data", 32'(tx_data), 32'hFF);
    check_val("t4_sof_busy", 32'(busy), 1);
    wait_idle_a(100);

    // Asynchronous reset after the second byte is accepted
    qa.push_back(8'hFF);
    qa.push_back(8'h01);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check_val("t5_valid", 32'(tx_valid), 0);
    check_val("t5_busy", 32'(busy), 0);
    check_val("t5_done", 32'(frame_done), 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("t5_quiet", 32'(tx_valid), 0);
    end
    check_val("t5_q_empty", qa.size(), 0);
    ch_data = {8'hFE, 8'h00, 8'h00, 8'd20};
    ch_sig  = 4'b0010;
    push6(48'hFF_14_01_02_FE_15);
    start = 1'b1; tick(); start = 1'b0;
    wait_idle_a(100);

    // Single channel, no checksum
    ch_data_b = 8'd100;
    qb.push_back(8'hFF);
    qb.push_back(8'h64);
    start_b = 1'b1; tick(); start_b = 1'b0;
    check_val("t6_valid", 32'(tx_valid_b), 1);
    tick();
    check_val("t6_busy_mid", 32'(busy_b), 1);
    tick();
    check_val("t6_done", 32'(frame_done_b), 1);
    check_val("t6_busy_end", 32'(busy_b), 0);
    check_val("t6_valid_end", 32'(tx_valid_b), 0);
    tick();
    check_val("t6_q_empty", qb.size(), 0);

    check_val("final_qa_empty", qa.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/protocol_framer.md
Name: protocol_framer

Overview:
- Sequential, parametrised successor to the combinational byte encoder.
- On a start request it snapshots CHANNELS channel values and switch flags.
- It then emits a complete frame byte-by-byte over a valid/ready handshake to the UART transmitter: start byte, one encoded byte per channel, optional checksum.
- Sits between the counter/switch capture logic and the UART TX.

Parameters:
CHANNELS, 4, number of channel bytes per frame (>=1)
SW_THRESH, 20, encoded values strictly below this are switcher channels
START_BYTE, 8'hFF, start-of-frame marker
SW_ON_CODE, 8'h01, byte sent for a switcher channel with sig=1
SW_OFF_CODE, 8'h02, byte sent for a switcher channel with sig=0
CHECKSUM_EN, 1, 1 = append checksum byte, 0 = omit

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  frame request pulse; sampled only in IDLE
ch_data  input  CHANNELS*8  channel values; channel 0 = bits [7:0], channel i = [8i+7:8i]
ch_sig  input  CHANNELS  switch state per channel; bit i = channel i
tx_data  output  8  byte presented to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART TX accepts byte when tx_valid && tx_ready
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- One clock domain: clk. Asynchronous, active-high reset.
- Reset:
  - state=IDLE; tx_data=0, tx_valid=0, busy=0, frame_done=0; snapshot registers and checksum accumulator cleared.
  - Reset mid-frame abandons the frame. No further bytes are emitted after reset deasserts until a new start.
- States: IDLE, SOF, CHAN, CSUM.
- IDLE, start=1:
  - Capture ch_data and ch_sig into internal registers.
  - Clear the checksum and channel index, go to SOF.
  - Later input changes do not affect the frame in flight.
- Latency: start at cycle t -> tx_valid=1, tx_data=START_BYTE, busy=1 at cycle t+1.
- Handshake:
  - tx_data is held stable while tx_valid=1 && tx_ready=0.
  - tx_valid never drops mid-frame.
  - On an accept edge, the next byte is loaded on the same edge (zero bubbles).
- Transitions:
  - SOF accepted -> CHAN, index 0.
  - CHAN accepted: if index = CHANNELS-1, go to CSUM (CHECKSUM_EN=1) or end-of-frame (CHECKSUM_EN=0); otherwise index+1.
  - CSUM accepted -> end-of-frame.
- Channel encoding, v = snapshot byte i:
  - v < SW_THRESH: SW_ON_CODE if sig[i]=1, else SW_OFF_CODE.
  - v >= SW_THRESH and v = START_BYTE: send START_BYTE-1 (escape clamp, so the marker never appears in the payload).
  - Otherwise send v.
  - The comparison is unsigned. v = SW_THRESH is data, not a switcher.
- Checksum:
  - 8-bit modulo-256 sum of the encoded channel bytes actually sent, excluding SOF, accumulated on each channel accept.
  - Transmitted byte = {1'b0, sum[6:0]}, so it never equals 0xFF.
- End-of-frame: the accept edge of the last byte sets state=IDLE, tx_valid=0, busy=0, and frame_done=1 for exactly that next cycle.
  - start in the frame_done cycle is accepted (state is IDLE).
- start while busy=1 is ignored (not queued).
- Frame length = 1 + CHANNELS + CHECKSUM_EN bytes.
- tx_data holds its last value when tx_valid=0. Only the tx_valid-qualified value is meaningful.

Test Plan:
1. Basic frame, no backpressure:
   - Stimulus: CHANNELS=4, tx_ready=1, ch0=19 sig1, ch1=0xFF, ch2=5 sig0, ch3=50 (ch_sig=4'b0001), pulse start.
   - Required: bytes FF 01 FE 02 32 33 on six consecutive cycles starting at t+1; frame_done pulses at t+7; busy high t+1..t+6.
2. Backpressure:
   - Stimulus: same frame, tx_ready toggling 1,0,0,1,...
   - Required: each byte held stable while not ready; byte order and values unchanged; no duplicates or drops.
3. Threshold and snapshot:
   - Stimulus: ch0=20 sig0, ch1=0 sig1, ch2=0 sig0, ch3=0xFE; change ch_data to all 0 the cycle after start.
   - Required: frame FF 14 01 02 FE 15, from the captured values.
4. Start while busy and back-to-back:
   - Stimulus: pulse start in the middle of a frame, then again in the frame_done cycle.
   - Required: first pulse ignored; second frame's SOF appears the following cycle.
5. Reset mid-frame:
   - Stimulus: assert reset asynchronously after the second byte is accepted.
   - Required: tx_valid, busy and frame_done go to 0 immediately; no bytes until the next start; the next frame is complete and correct.
6. CHECKSUM_EN=0, CHANNELS=1:
   - Stimulus: ch0=100, pulse start.
   - Required: frame FF 64 only; frame_done after the second accept.
